// File: rtl/dram_ctrl_pkg.sv
// Shared definitions for the DRAM read scheduler.
// Holds the default bus widths, the scheduler FSM state type and the
// response buffer entry layout {data, id, last}.
package dram_ctrl_pkg;

  localparam int DRAM_ADDR_WIDTH = 24;
  localparam int DRAM_DATA_WIDTH = 8;
  localparam int DRAM_LEN_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_DRAIN
  } sched_state_t;

  typedef struct packed {
    logic [DRAM_DATA_WIDTH-1:0] data;
    logic                       id;
    logic                       last;
  } rsp_entry_t;

endpackage

// File: rtl/dram_rd_sched_if.sv
// Requester-side bus of the DRAM read scheduler.
// Carries the two burst request channels (valid/ready/addr/len, requester i
// packed at slice i) and the single response channel (valid/ready/data/id/last).
// master: requester side. slave: scheduler side.
interface dram_rd_sched_if
  import dram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DRAM_DATA_WIDTH,
  parameter int LEN_WIDTH  = DRAM_LEN_WIDTH
);

  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*LEN_WIDTH-1:0]  req_len;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    rsp_id;
  logic                    rsp_last;

  modport master (
    output req_valid, req_addr, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_last
  );

  modport slave (
    input  req_valid, req_addr, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_last
  );

endinterface

// File: rtl/dram_rsp_fifo.sv
// Synchronous response buffer for the DRAM read scheduler.
// Ports: clk, rst (sync, active-high), push/push_entry (write),
// pop (advance head), head (current oldest entry), count (occupancy).
module dram_rsp_fifo
  import dram_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  rsp_entry_t             push_entry,
  input  logic                   pop,
  output rsp_entry_t             head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  rsp_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            empty;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dram_rd_sched.sv
// Two-requester DRAM burst read scheduler.
// Ports: clk, rst (sync, active-high); bus (slave side of dram_rd_sched_if:
// requests in, responses out); dram_addr (registered read address);
// dram_data (read data, valid the cycle after dram_addr is sampled);
// busy (scheduler not idle).
// A granted burst issues base..base+len one address per cycle, throttled so
// every issued read has a guaranteed buffer slot, and returns bytes in order.
module dram_rd_sched
  import dram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DRAM_DATA_WIDTH,
  parameter int LEN_WIDTH  = DRAM_LEN_WIDTH,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  dram_rd_sched_if.slave        bus,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  input  logic [DATA_WIDTH-1:0] dram_data,
  output logic                  busy
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  sched_state_t          state;
  logic                  prio;       // requester that wins when both request
  logic                  id_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  cnt;        // index of the most recently issued byte
  logic [LEN_WIDTH-1:0]  cnt_next;

  // s1: read whose address is on dram_addr this cycle.
  // s2: read whose data is on dram_data this cycle (pushed at the next edge).
  logic                  s1_valid, s1_last;
  logic                  s2_valid, s2_last;

  logic                  grant_id;
  logic [1:0]            grant;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LEN_WIDTH-1:0]  sel_len;

  logic [CW-1:0]         buf_count;
  logic [CW:0]           occ;
  logic                  pop;
  logic                  can_issue;
  logic                  burst_done;
  logic                  drained;
  rsp_entry_t            push_entry;
  rsp_entry_t            head;

  // Arbitration
  always_comb begin
    grant_id = (bus.req_valid == 2'b11) ? prio : bus.req_valid[1];
    grant    = '0;
    if (bus.req_valid != 2'b00) grant = grant_id ? 2'b10 : 2'b01;
  end

  assign bus.req_ready = (state == ST_IDLE && !rst) ? grant : 2'b00;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign sel_addr      = grant_id ? bus.req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                  : bus.req_addr[0 +: ADDR_WIDTH];
  assign sel_len       = grant_id ? bus.req_len[LEN_WIDTH +: LEN_WIDTH]
                                  : bus.req_len[0 +: LEN_WIDTH];

  // Flow control: entries already buffered plus reads still in the DRAM
  // pipeline, less the one leaving this cycle, must leave room for one more.
  assign pop        = bus.rsp_valid && bus.rsp_ready;
  assign occ        = {1'b0, buf_count} + (CW+1)'(s1_valid) + (CW+1)'(s2_valid)
                      - (CW+1)'(pop);
  assign can_issue  = (occ < (CW+1)'(BUF_DEPTH));
  assign cnt_next   = cnt + LEN_WIDTH'(1);
  assign burst_done = (cnt == len_q);
  // Buffer becomes empty at this edge (pop only happens when count > 0).
  assign drained    = !s1_valid && !s2_valid && (buf_count == CW'(pop));

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      dram_addr <= '0;
      prio      <= 1'b0;
      id_q      <= 1'b0;
      len_q     <= '0;
      cnt       <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s1_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The buffer is empty in IDLE, so byte 0 issues on the accept edge.
          if (accept) begin
            dram_addr <= sel_addr;
            len_q     <= sel_len;
            cnt       <= '0;
            id_q      <= grant_id;
            prio      <= ~grant_id;
            s1_valid  <= 1'b1;
            s1_last   <= (sel_len == '0);
            state     <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (burst_done) begin
            state <= ST_DRAIN;
          end else if (can_issue) begin
            dram_addr <= dram_addr + ADDR_WIDTH'(1);
            cnt       <= cnt_next;
            s1_valid  <= 1'b1;
            s1_last   <= (cnt_next == len_q);
            if (cnt_next == len_q) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drained) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.data = dram_data;
    push_entry.id   = id_q;
    push_entry.last = s2_last;
  end

  dram_rsp_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (s2_valid),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (buf_count)
  );

  assign bus.rsp_valid = (buf_count != '0);
  assign bus.rsp_data  = head.data;
  assign bus.rsp_id    = head.id;
  assign bus.rsp_last  = head.last;

endmodule
